vga_matrix_renderer: RTL and testbench
======================================

VGA_MATRIX_RENDERER -- requirements
Module: vga_matrix_renderer

Interface
REQ-001 Parameter CELL_W, default 160, cell width in pixels (4 columns x 160 = 640).
REQ-002 Parameter CELL_H, default 120, cell height in lines (4 rows x 120 = 480).
REQ-003 Parameter LAT, default 3, fixed pipeline latency in clk cycles; not user-alterable, documented for integration.
REQ-004 Interface: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  pixel clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 h_count  in  11  horizontal pixel position from the horizontal timing stage.
REQ-008 v_count  in  11  vertical line position from the vertical timing stage.
REQ-009 hsync, vsync  in  1 each  active-low syncs, aligned with h_count/v_count.
REQ-010 hblank, vblank  in  1 each  active-high blanking, aligned with counts.
REQ-011 wr_en  in  1  write strobe from the matrix multiplier.
REQ-012 wr_addr  in  4  element index, row*4+col.
REQ-013 wr_data  in  8  unsigned result element.
REQ-014 commit_req  in  1  level; producer holds high until commit_ack.
REQ-015 commit_ack  out  1  one-cycle pulse when shadow copied to display.
REQ-016 vga_r, vga_g, vga_b  out  4 each  colour outputs.
REQ-017 vga_hsync, vga_vsync  out  1 each  syncs delayed LAT cycles.

Function
REQ-018 Block SHALL hold two 16x8 arrays: shadow (written by wr_*) and display (read by video path).
REQ-019 wr_en=1 SHALL write wr_data to shadow[wr_addr] at next edge; display never written directly.
REQ-020 Block SHALL register vblank to detect its rising edge (vblank=1, previous=0).
REQ-021 On vblank rising edge with commit_req=1, block SHALL copy all 16 shadow entries to display and assert commit_ack for exactly that following cycle.
REQ-022 Write coincident with copy: display receives pre-write shadow value; shadow receives the write.
REQ-023 commit_ack SHALL NOT re-assert until commit_req deasserts and reasserts (edge-armed), at most one ack per frame.
REQ-024 commit_req rising mid-frame SHALL wait for next vblank rising edge; no tearing of displayed frame.
REQ-025 Stage 1 SHALL compute col = 0/1/2/3 for h_count <160/<320/<480/else, row likewise on v_count with 120/240/360, via comparators (no divider); register col, row, border flag, syncs, blank=hblank|vblank.
REQ-026 Border flag SHALL be 1 when h_count in {0,160,320,480,639} or v_count in {0,120,240,360,479}.
REQ-027 Stage 2 SHALL register display[row*4+col] with all stage-1 side signals.
REQ-028 Stage 3 SHALL output: blank=1 -> RGB 0; else border=1 -> RGB F/F/F; else r=data[7:4], g=data[7:4], b=data[3:0].
REQ-029 vga_hsync/vga_vsync SHALL equal hsync/vsync delayed exactly LAT=3 cycles, aligned with RGB.
REQ-030 Counts >=640 or >=480 SHALL produce RGB 0 via blank; index logic saturates at 3.

Reset
REQ-031 While reset=1 at an edge: shadow and display all 0, commit_ack 0, RGB 0, vga_hsync/vga_vsync 1, pipeline side signals blank=1, ack arm set, vblank history 0.
REQ-032 Reset mid-operation SHALL abort any pending commit without ack; first valid output LAT cycles after reset release.

Verification
REQ-033 Reset, counts at (200,130), no blank -> after 3 cycles RGB 0/0/0 (display zero), syncs track input delayed 3.
REQ-034 Write shadow[5]=0xA3, commit_req=1, vblank 0->1 -> commit_ack one cycle; next frame (200,130) -> RGB A/A/3.
REQ-035 Write shadow[5]=0x7C without commit_req across vblank -> display pixel (200,130) stays previous value, no ack.
REQ-036 h_count=160 or v_count=479, unblanked -> RGB F/F/F; hblank=1 at same point -> RGB 0.
REQ-037 wr_en to addr 5 on same edge as copy -> display[5] gets old shadow value, shadow[5] new value; held commit_req over two vblanks -> exactly one ack.
REQ-038 Assert reset with commit_req high one cycle before vblank edge -> no commit_ack, display all 0.

Source files
------------

// File: rtl/vga_matrix_renderer.sv
// Renders a 4x4 matrix of 8-bit results as a 640x480 grid of coloured cells.
// Writes land in a shadow array; the shadow is copied to the display array
// on a vblank rising edge when the producer requests a commit, so a frame is
// never torn. The video path is a fixed 3-stage pipeline; syncs are delayed
// to stay aligned with the colour outputs.
module vga_matrix_renderer #(
  parameter int unsigned CELL_W = 160,
  parameter int unsigned CELL_H = 120,
  parameter int unsigned LAT    = 3   // fixed; the video path has three register stages
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        commit_req,
  output logic        commit_ack,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync
);

  localparam int unsigned CntW  = 11;
  localparam int unsigned Cells = 16;

  localparam logic [CntW-1:0] H1   = CntW'(CELL_W);
  localparam logic [CntW-1:0] H2   = CntW'(2 * CELL_W);
  localparam logic [CntW-1:0] H3   = CntW'(3 * CELL_W);
  localparam logic [CntW-1:0] HEnd = CntW'(4 * CELL_W - 1);
  localparam logic [CntW-1:0] V1   = CntW'(CELL_H);
  localparam logic [CntW-1:0] V2   = CntW'(2 * CELL_H);
  localparam logic [CntW-1:0] V3   = CntW'(3 * CELL_H);
  localparam logic [CntW-1:0] VEnd = CntW'(4 * CELL_H - 1);

  // Matrix storage
  logic [7:0] shadow_q  [Cells];
  logic [7:0] display_q [Cells];

  // Commit handshake state
  logic vblank_q;
  logic arm_q, arm_d;
  logic commit_ack_q, commit_ack_d;
  logic vblank_rise_c;
  logic commit_fire_c;

  // Stage 1 registers
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic       border1_q, border1_d;
  logic       blank1_q, blank1_d;

  // Stage 2 registers
  logic [7:0] pix2_q;
  logic       border2_q;
  logic       blank2_q;

  // Stage 3 registers
  logic [3:0] r_q, r_d;
  logic [3:0] g_q, g_d;
  logic [3:0] b_q, b_d;

  // Sync delay lines, one bit per pipeline stage
  logic [LAT-1:0] hs_pipe_q;
  logic [LAT-1:0] vs_pipe_q;

  // Commit decision: edge-armed, fires only on a vblank rising edge
  always_comb begin
    vblank_rise_c = vblank & ~vblank_q;
    commit_fire_c = vblank_rise_c & commit_req & arm_q;
    commit_ack_d  = commit_fire_c;
    arm_d         = arm_q;
    if (commit_fire_c) begin
      arm_d = 1'b0;
    end else if (!commit_req) begin
      arm_d = 1'b1;
    end
  end

  // Commit handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q     <= 1'b0;
      arm_q        <= 1'b1;
      commit_ack_q <= 1'b0;
    end else begin
      vblank_q     <= vblank;
      arm_q        <= arm_d;
      commit_ack_q <= commit_ack_d;
    end
  end

  // Shadow writes and shadow-to-display copy; the copy sees pre-write shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Cells; i++) begin
        shadow_q[i]  <= 8'h00;
        display_q[i] <= 8'h00;
      end
    end else begin
      if (wr_en) begin
        shadow_q[wr_addr] <= wr_data;
      end
      if (commit_fire_c) begin
        for (int i = 0; i < Cells; i++) begin
          display_q[i] <= shadow_q[i];
        end
      end
    end
  end

  // Stage 1: cell index by comparison, grid border detection, blank merge
  always_comb begin
    col_d = 2'd3;
    row_d = 2'd3;
    if (h_count < H1) begin
      col_d = 2'd0;
    end else if (h_count < H2) begin
      col_d = 2'd1;
    end else if (h_count < H3) begin
      col_d = 2'd2;
    end
    if (v_count < V1) begin
      row_d = 2'd0;
    end else if (v_count < V2) begin
      row_d = 2'd1;
    end else if (v_count < V3) begin
      row_d = 2'd2;
    end
    border1_d = (h_count == '0) || (h_count == H1) || (h_count == H2) ||
                (h_count == H3) || (h_count == HEnd) ||
                (v_count == '0) || (v_count == V1) || (v_count == V2) ||
                (v_count == V3) || (v_count == VEnd);
    blank1_d  = hblank | vblank;
  end

  // Stage 3 colour selection from stage 2 data
  always_comb begin
    r_d = pix2_q[7:4];
    g_d = pix2_q[7:4];
    b_d = pix2_q[3:0];
    if (blank2_q) begin
      r_d = 4'h0;
      g_d = 4'h0;
      b_d = 4'h0;
    end else if (border2_q) begin
      r_d = 4'hF;
      g_d = 4'hF;
      b_d = 4'hF;
    end
  end

  // Video pipeline registers (stages 1-3) and sync delay lines
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      border1_q <= 1'b0;
      blank1_q  <= 1'b1;
      pix2_q    <= 8'h00;
      border2_q <= 1'b0;
      blank2_q  <= 1'b1;
      r_q       <= 4'h0;
      g_q       <= 4'h0;
      b_q       <= 4'h0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      border1_q <= border1_d;
      blank1_q  <= blank1_d;
      pix2_q    <= display_q[{row_q, col_q}];
      border2_q <= border1_q;
      blank2_q  <= blank1_q;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_pipe_q <= {hs_pipe_q[LAT-2:0], hsync};
      vs_pipe_q <= {vs_pipe_q[LAT-2:0], vsync};
    end
  end

  assign commit_ack = commit_ack_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
  assign vga_hsync  = hs_pipe_q[LAT-1];
  assign vga_vsync  = vs_pipe_q[LAT-1];

endmodule

// File: tb/tb_vga_matrix_renderer.sv
// Directed bench for vga_matrix_renderer: reset, latency, commit handshake,
// borders/blanking, coincident write+copy and reset-aborted commit.
module tb_vga_matrix_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        hsync, vsync, hblank, vblank;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit_req;
  logic        commit_ack;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync;

  int checks   = 0;
  int failures = 0;

  vga_matrix_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .h_count    (h_count),
    .v_count    (v_count),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_px(input int h, input int v, input logic hb, input logic vb);
    h_count = 11'(h);
    v_count = 11'(v);
    hblank  = hb;
    vblank  = vb;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    commit_req = 1'b0; hsync = 1'b0; vsync = 1'b0;
    set_px(200, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if (commit_ack !== 1'b0) begin
      failures++; $display("FAIL reset_ack got=%b exp=0", commit_ack);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      failures++; $display("FAIL reset_rgb got=%h exp=000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if ({vga_hsync, vga_vsync} !== 2'b11) begin
      failures++; $display("FAIL reset_syncs got=%b exp=11", {vga_hsync, vga_vsync});
    end
  endtask

  task automatic test_latency_zero();
    hsync = 1'b0; vsync = 1'b1;
    set_px(200, 130, 1'b0, 1'b0);
    reset = 1'b0;
    step(2);
    checks++;
    if (vga_hsync !== 1'b1) begin
      failures++; $display("FAIL lat_hsync_early got=%b exp=1", vga_hsync);
    end
    step(1);
    checks++;
    if ({vga_hsync, vga_vsync} !== 2'b01) begin
      failures++; $display("FAIL lat_syncs got=%b exp=01", {vga_hsync, vga_vsync});
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      failures++; $display("FAIL lat_rgb_zero got=%h exp=000", {vga_r, vga_g, vga_b});
    end
    hsync = 1'b1;
    step(3);
    checks++;
    if (vga_hsync !== 1'b1) begin
      failures++; $display("FAIL lat_hsync_rise got=%b exp=1", vga_hsync);
    end
  endtask

  task automatic test_commit();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hA3;
    step(1);
    wr_en = 1'b0;
    commit_req = 1'b1;
    set_px(200, 130, 1'b0, 1'b1);
    step(1);
    checks++;
    if (commit_ack !== 1'b1) begin
      failures++; $display("FAIL commit_ack_pulse got=%b exp=1", commit_ack);
    end
    step(1);
    checks++;
    if (commit_ack !== 1'b0) begin
      failures++; $display("FAIL commit_ack_single got=%b exp=0", commit_ack);
    end
    commit_req = 1'b0;
    set_px(200, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'hAA3) begin
      failures++; $display("FAIL commit_rgb got=%h exp=aa3", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_no_commit();
    int acks = 0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h7C;
    step(1);
    wr_en = 1'b0;
    set_px(200, 130, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (commit_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++; $display("FAIL nocommit_acks got=%0d exp=0", acks);
    end
    set_px(200, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'hAA3) begin
      failures++; $display("FAIL nocommit_rgb got=%h exp=aa3", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_border();
    int hs [5] = '{160, 200, 639, 0, 480};
    int vs [5] = '{130, 479, 130, 50, 240};
    for (int i = 0; i < 5; i++) begin
      set_px(hs[i], vs[i], 1'b0, 1'b0);
      step(3);
      checks++;
      if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
        failures++;
        $display("FAIL border_%0d_%0d got=%h exp=fff", hs[i], vs[i], {vga_r, vga_g, vga_b});
      end
    end
    set_px(160, 130, 1'b1, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      failures++; $display("FAIL border_hblank got=%h exp=000", {vga_r, vga_g, vga_b});
    end
    set_px(159, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      failures++; $display("FAIL cell4_interior got=%h exp=000", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    // shadow[5]=7C, display[5]=A3; commit with a coincident write of 55
    commit_req = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
    set_px(200, 130, 1'b0, 1'b1);
    step(1);
    wr_en = 1'b0;
    if (commit_ack === 1'b1) acks++;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (commit_ack === 1'b1) acks++;
    end
    set_px(200, 130, 1'b0, 1'b0);
    step(2);
    if (commit_ack === 1'b1) acks++;
    // second vblank with commit_req still held
    set_px(200, 130, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (commit_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      failures++; $display("FAIL held_req_acks got=%0d exp=1", acks);
    end
    set_px(200, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h77C) begin
      failures++; $display("FAIL coincident_display got=%h exp=77c", {vga_r, vga_g, vga_b});
    end
    // re-arm and commit again to expose the written shadow value
    commit_req = 1'b0;
    step(2);
    commit_req = 1'b1;
    step(2);
    set_px(200, 130, 1'b0, 1'b1);
    step(1);
    checks++;
    if (commit_ack !== 1'b1) begin
      failures++; $display("FAIL rearm_ack got=%b exp=1", commit_ack);
    end
    commit_req = 1'b0;
    set_px(200, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h555) begin
      failures++; $display("FAIL coincident_shadow got=%h exp=555", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    commit_req = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    set_px(200, 130, 1'b0, 1'b1);
    step(1);
    if (commit_ack === 1'b1) acks++;
    step(1);
    if (commit_ack === 1'b1) acks++;
    set_px(200, 130, 1'b0, 1'b0);
    commit_req = 1'b0;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (commit_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++; $display("FAIL abort_acks got=%0d exp=0", acks);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      failures++; $display("FAIL abort_display got=%h exp=000", {vga_r, vga_g, vga_b});
    end
    // commit after reset: shadow was cleared too
    commit_req = 1'b1;
    set_px(200, 130, 1'b0, 1'b1);
    step(1);
    checks++;
    if (commit_ack !== 1'b1) begin
      failures++; $display("FAIL post_reset_ack got=%b exp=1", commit_ack);
    end
    commit_req = 1'b0;
    set_px(200, 130, 1'b0, 1'b0);
    step(3);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      failures++; $display("FAIL post_reset_shadow got=%h exp=000", {vga_r, vga_g, vga_b});
    end
  endtask

  initial begin
    test_reset();
    test_latency_zero();
    test_commit();
    test_no_commit();
    test_border();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
